// File: rtl/music_box_mode_arbiter_if.sv
// Mode arbiter bus: button/done/abort/clear controls in, arbitration status out.
// The controller side (master) drives the controls; the arbiter (slave) drives status.
`timescale 1ns/1ps
interface music_box_mode_arbiter_if #(
    parameter int unsigned NUM_MODES = 4,
    parameter int unsigned CNT_W     = 16
);
    logic                 tick_1khz;
    logic [NUM_MODES-1:0] request_n;
    logic [NUM_MODES-1:0] mode_done;
    logic                 abort_n;
    logic                 error_clear;
    logic [3:0]           state_code;
    logic [NUM_MODES-1:0] mode_active;
    logic                 mode_start;
    logic [CNT_W-1:0]     elapsed_ms;
    logic                 error_flag;

    modport master (
        output tick_1khz, request_n, mode_done, abort_n, error_clear,
        input  state_code, mode_active, mode_start, elapsed_ms, error_flag
    );

    modport slave (
        input  tick_1khz, request_n, mode_done, abort_n, error_clear,
        output state_code, mode_active, mode_start, elapsed_ms, error_flag
    );
endinterface

// File: rtl/music_box_mode_arbiter.sv
// Music box mode arbiter: grants one mode at a time (lowest button index wins),
// times the running mode in ms ticks and traps overruns in an ERROR state.
`timescale 1ns/1ps
module music_box_mode_arbiter #(
    parameter int unsigned NUM_MODES  = 4,
    parameter int unsigned TIMEOUT_MS = 60000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clock_50Mhz,
    input  logic                          reset_n,
    music_box_mode_arbiter_if.slave       bus
);
    localparam int unsigned    IDX_W        = 3;
    localparam logic [3:0]     CODE_IDLE    = 4'd0;
    localparam logic [3:0]     CODE_ERROR   = 4'd8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_MS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RELEASE,
        S_ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           state_code_q, state_code_d;
    logic [NUM_MODES-1:0] mode_active_q, mode_active_d;
    logic                 mode_start_q, mode_start_d;
    logic [CNT_W-1:0]     elapsed_q, elapsed_d;
    logic                 error_flag_q, error_flag_d;

    logic                 all_released;
    logic                 done_hit;
    logic                 timeout_hit;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_MODES-1:0] win_oh;

    // Lowest asserted request index wins; scanning downward leaves the lowest last.
    always_comb begin
        win_idx = '0;
        win_oh  = '0;
        for (int i = int'(NUM_MODES) - 1; i >= 0; i--) begin
            if (!bus.request_n[i]) begin
                win_idx    = IDX_W'(i);
                win_oh     = '0;
                win_oh[i]  = 1'b1;
            end
        end
    end

    assign all_released = &bus.request_n;
    // mode_active_q is one-hot on the latched mode, so it selects only done[k].
    assign done_hit     = |(bus.mode_done & mode_active_q);
    assign timeout_hit  = (TIMEOUT_MS != 0) && bus.tick_1khz && (elapsed_q == TIMEOUT_LAST);

    always_comb begin
        state_d       = state_q;
        state_code_d  = state_code_q;
        mode_active_d = mode_active_q;
        mode_start_d  = 1'b0;
        elapsed_d     = elapsed_q;
        error_flag_d  = error_flag_q;

        case (state_q)
            S_IDLE: begin
                if (!all_released) begin
                    state_d       = S_ACTIVE;
                    state_code_d  = 4'(win_idx) + 4'd1;
                    mode_active_d = win_oh;
                    mode_start_d  = 1'b1;
                    elapsed_d     = '0;
                end
            end
            S_ACTIVE: begin
                if (bus.tick_1khz && (elapsed_q != '1)) begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                end
                if (!bus.abort_n || done_hit) begin
                    state_d       = S_RELEASE;
                    state_code_d  = CODE_IDLE;
                    mode_active_d = '0;
                end else if (timeout_hit) begin
                    state_d       = S_ERROR;
                    state_code_d  = CODE_ERROR;
                    mode_active_d = '0;
                    error_flag_d  = 1'b1;
                end
            end
            S_RELEASE: begin
                // Wait for every button to let go so a held button cannot retrigger.
                if (all_released && bus.abort_n) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (bus.error_clear && all_released) begin
                    state_d       = S_IDLE;
                    state_code_d  = CODE_IDLE;
                    error_flag_d  = 1'b0;
                end
            end
            default: begin
                state_d       = S_IDLE;
                state_code_d  = CODE_IDLE;
                mode_active_d = '0;
                error_flag_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            state_code_q  <= CODE_IDLE;
            mode_active_q <= '0;
            mode_start_q  <= 1'b0;
            elapsed_q     <= '0;
            error_flag_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            state_code_q  <= state_code_d;
            mode_active_q <= mode_active_d;
            mode_start_q  <= mode_start_d;
            elapsed_q     <= elapsed_d;
            error_flag_q  <= error_flag_d;
        end
    end

    assign bus.state_code  = state_code_q;
    assign bus.mode_active = mode_active_q;
    assign bus.mode_start  = mode_start_q;
    assign bus.elapsed_ms  = elapsed_q;
    assign bus.error_flag  = error_flag_q;
endmodule

// File: tb/tb_music_box_mode_arbiter.sv
// Bench for music_box_mode_arbiter: two instances (short timeout / timeout disabled
// with a 3-bit counter) driven in lockstep and compared against a phase-level model.
`timescale 1ns/1ps
module tb_music_box_mode_arbiter;
    localparam int NM = 4;

    localparam int P_IDLE    = 0;
    localparam int P_ACTIVE  = 1;
    localparam int P_RELEASE = 2;
    localparam int P_ERROR   = 3;

    typedef struct {
        int phase;
        int k;
        int el;
        bit start;
    } mdl_t;

    logic          clock_50Mhz = 1'b0;
    logic          reset_n;
    logic          tick;
    logic [NM-1:0] req;
    logic [NM-1:0] done;
    logic          abort_n;
    logic          eclr;

    int   checks = 0;
    int   errors = 0;
    mdl_t ma, mb;

    always #10 clock_50Mhz = ~clock_50Mhz;

    music_box_mode_arbiter_if #(.NUM_MODES(NM), .CNT_W(16)) bus_a ();
    music_box_mode_arbiter_if #(.NUM_MODES(NM), .CNT_W(3))  bus_b ();

    assign bus_a.tick_1khz   = tick;
    assign bus_a.request_n   = req;
    assign bus_a.mode_done   = done;
    assign bus_a.abort_n     = abort_n;
    assign bus_a.error_clear = eclr;
    assign bus_b.tick_1khz   = tick;
    assign bus_b.request_n   = req;
    assign bus_b.mode_done   = done;
    assign bus_b.abort_n     = abort_n;
    assign bus_b.error_clear = eclr;

    music_box_mode_arbiter #(.NUM_MODES(NM), .TIMEOUT_MS(5), .CNT_W(16)) dut_a (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .bus         (bus_a)
    );

    music_box_mode_arbiter #(.NUM_MODES(NM), .TIMEOUT_MS(0), .CNT_W(3)) dut_b (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .bus         (bus_b)
    );

    function automatic mdl_t model_reset();
        mdl_t m;
        m.phase = P_IDLE;
        m.k     = 0;
        m.el    = 0;
        m.start = 1'b0;
        return m;
    endfunction

    // One clock of the arbiter rules, expressed on a phase/mode/elapsed view.
    function automatic mdl_t model_step(mdl_t m, int to, int maxel, bit tk,
                                        logic [NM-1:0] rq, logic [NM-1:0] dn,
                                        bit ab, bit ec);
        mdl_t n;
        int   w;
        n       = m;
        n.start = 1'b0;
        w       = -1;
        for (int i = NM - 1; i >= 0; i--) if (!rq[i]) w = i;
        case (m.phase)
            P_IDLE: if (w >= 0) begin
                n.phase = P_ACTIVE;
                n.k     = w;
                n.el    = 0;
                n.start = 1'b1;
            end
            P_ACTIVE: begin
                if (tk && m.el < maxel) n.el = m.el + 1;
                if (!ab)                                   n.phase = P_RELEASE;
                else if (dn[m.k])                          n.phase = P_RELEASE;
                else if (to != 0 && tk && m.el == to - 1)  n.phase = P_ERROR;
            end
            P_RELEASE: if (w < 0 && ab) n.phase = P_IDLE;
            default:   if (w < 0 && ec) n.phase = P_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] e_code(mdl_t m);
        if (m.phase == P_ACTIVE) return 32'(m.k + 1);
        if (m.phase == P_ERROR)  return 32'd8;
        return 32'd0;
    endfunction

    function automatic logic [31:0] e_act(mdl_t m);
        if (m.phase == P_ACTIVE) return 32'd1 << m.k;
        return 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic verify_all();
        check("a.state_code",  32'(bus_a.state_code),  e_code(ma));
        check("a.mode_active", 32'(bus_a.mode_active), e_act(ma));
        check("a.mode_start",  32'(bus_a.mode_start),  32'(ma.start));
        check("a.elapsed_ms",  32'(bus_a.elapsed_ms),  32'(ma.el));
        check("a.error_flag",  32'(bus_a.error_flag),  32'(ma.phase == P_ERROR));
        check("b.state_code",  32'(bus_b.state_code),  e_code(mb));
        check("b.mode_active", 32'(bus_b.mode_active), e_act(mb));
        check("b.mode_start",  32'(bus_b.mode_start),  32'(mb.start));
        check("b.elapsed_ms",  32'(bus_b.elapsed_ms),  32'(mb.el));
        check("b.error_flag",  32'(bus_b.error_flag),  32'(mb.phase == P_ERROR));
    endtask

    task automatic cycle();
        @(posedge clock_50Mhz);
        if (!reset_n) begin
            ma = model_reset();
            mb = model_reset();
        end else begin
            ma = model_step(ma, 5, 65535, tick, req, done, abort_n, eclr);
            mb = model_step(mb, 0, 7,     tick, req, done, abort_n, eclr);
        end
        #1;
        verify_all();
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cycle();
        tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        req     = '1;
        done    = '0;
        abort_n = 1'b1;
        eclr    = 1'b0;
        ma      = model_reset();
        mb      = model_reset();
        #5;
        verify_all();
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();

        // Single button on mode 1: one-cycle start pulse, then done releases it.
        req = 4'b1101;
        cycle();
        check("req1 code", 32'(bus_a.state_code), 32'd2);
        check("req1 active", 32'(bus_a.mode_active), 32'b0010);
        check("req1 start", 32'(bus_a.mode_start), 32'd1);
        req = '1;
        cycle();
        check("req1 start drop", 32'(bus_a.mode_start), 32'd0);
        done = 4'b0010;
        cycle();
        done = '0;
        cycle();

        // Simultaneous requests: lowest wins; done of another mode ignored.
        req = 4'b0110;
        cycle();
        check("prio code", 32'(bus_a.state_code), 32'd1);
        req  = '1;
        done = 4'b0010;
        cycle();
        check("foreign done", 32'(bus_a.state_code), 32'd1);
        done = 4'b0001;
        cycle();
        check("own done", 32'(bus_a.state_code), 32'd0);
        done = '0;
        cycle();

        // Held button through completion stays in release without retrigger.
        req = 4'b1011;
        cycle();
        done = 4'b0100;
        cycle();
        done = '0;
        repeat (3) begin
            cycle();
            check("held no start", 32'(bus_a.mode_start), 32'd0);
        end
        req = '1;
        cycle();
        cycle();

        // Mode 3 overruns on instance a; instance b has no timeout.
        req = 4'b0111;
        cycle();
        req = '1;
        ticks(5);
        check("to code", 32'(bus_a.state_code), 32'd8);
        check("to flag", 32'(bus_a.error_flag), 32'd1);
        check("to elapsed", 32'(bus_a.elapsed_ms), 32'd5);
        check("no-to code", 32'(bus_b.state_code), 32'd4);
        eclr = 1'b1;
        cycle();
        eclr    = 1'b0;
        abort_n = 1'b0;
        cycle();
        abort_n = 1'b1;
        cycle();

        // Counter saturation on the 3-bit instance.
        req = 4'b1110;
        cycle();
        req = '1;
        ticks(9);
        check("sat elapsed", 32'(bus_b.elapsed_ms), 32'd7);
        eclr    = 1'b1;
        abort_n = 1'b0;
        cycle();
        eclr    = 1'b0;
        abort_n = 1'b1;
        cycle();

        // Done on the same cycle as the timeout tick wins over the timeout.
        req = 4'b1110;
        cycle();
        req = '1;
        ticks(4);
        tick = 1'b1;
        done = 4'b0001;
        cycle();
        check("done vs to code", 32'(bus_a.state_code), 32'd0);
        check("done vs to flag", 32'(bus_a.error_flag), 32'd0);
        tick = 1'b0;
        done = '0;
        cycle();

        // Abort in active.
        req = 4'b1011;
        cycle();
        req     = '1;
        abort_n = 1'b0;
        cycle();
        check("abort code", 32'(bus_a.state_code), 32'd0);
        abort_n = 1'b1;
        cycle();

        // Asynchronous reset mid-active.
        req = 4'b1110;
        cycle();
        req = '1;
        ticks(3);
        check("pre-rst elapsed", 32'(bus_a.elapsed_ms), 32'd3);
        #3;
        reset_n = 1'b0;
        ma      = model_reset();
        mb      = model_reset();
        #1;
        verify_all();
        check("rst code", 32'(bus_a.state_code), 32'd0);
        check("rst elapsed", 32'(bus_a.elapsed_ms), 32'd0);
        req = 4'b1110;
        cycle();
        reset_n = 1'b1;
        cycle();
        check("post-rst start", 32'(bus_a.mode_start), 32'd1);
        req     = '1;
        abort_n = 1'b0;
        cycle();
        abort_n = 1'b1;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            req     = ($urandom_range(0, 3) == 0) ? NM'($urandom) : '1;
            done    = ($urandom_range(0, 3) == 0) ? NM'($urandom) : '0;
            tick    = ($urandom_range(0, 2) == 0);
            abort_n = ($urandom_range(0, 15) != 0);
            eclr    = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/music_box_mode_arbiter.md
MUSIC_BOX_MODE_ARBITER -- requirements
Module: music_box_mode_arbiter

Interface
REQ-001 Parameter NUM_MODES, default 4, number of mode request/complete channels; legal 1..7.
REQ-002 Parameter TIMEOUT_MS, default 60000, maximum ms ticks allowed in ACTIVE before ERROR; 0 disables timeout.
REQ-003 Parameter CNT_W, default 16, width of elapsed_ms; TIMEOUT_MS SHALL fit in CNT_W bits.
REQ-004 clock_50Mhz  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 tick_1khz  in  1  one-cycle enable pulse at 1 kHz, synchronous to clock_50Mhz.
REQ-007 request_n  in  NUM_MODES  debounced active-low mode buttons; bit k requests mode k.
REQ-008 mode_done  in  NUM_MODES  completion from mode controller k; level, high = done.
REQ-009 abort_n  in  1  active-low abort of the running mode.
REQ-010 error_clear  in  1  active-high request to leave ERROR.
REQ-011 state_code  out  4  0 = idle/release, k+1 = mode k active, 8 = error.
REQ-012 mode_active  out  NUM_MODES  one-hot enable of the running mode; all zero otherwise.
REQ-013 mode_start  out  1  one-cycle pulse on first ACTIVE cycle.
REQ-014 elapsed_ms  out  CNT_W  ms ticks spent in current/last mode.
REQ-015 error_flag  out  1  high while in ERROR.

Function
REQ-016 FSM states SHALL be IDLE, ACTIVE, RELEASE, ERROR; all outputs registered.
REQ-017 IDLE: any request_n bit low -> ACTIVE with winner k = lowest asserted index; others ignored.
REQ-018 Latency: request sampled at edge N -> state_code, mode_active, mode_start valid after edge N.
REQ-019 Entry to ACTIVE SHALL clear elapsed_ms to 0 and latch k until leaving ACTIVE.
REQ-020 ACTIVE: elapsed_ms increments by 1 per tick_1khz, saturating at all-ones.
REQ-021 ACTIVE exit priority: abort_n low -> RELEASE; else mode_done[k] high -> RELEASE; else timeout -> ERROR.
REQ-022 Timeout: tick_1khz high with elapsed_ms == TIMEOUT_MS-1 (TIMEOUT_MS != 0) -> ERROR next cycle.
REQ-023 mode_done bits other than k and all request_n changes SHALL be ignored in ACTIVE.
REQ-024 RELEASE: state_code 0, mode_active 0; exit to IDLE when all request_n and abort_n high in the same cycle.
REQ-025 RELEASE SHALL prevent a held button from retriggering its mode.
REQ-026 ERROR: state_code 8, error_flag 1, mode_active 0; exit to IDLE only when error_clear high and all request_n high.
REQ-027 elapsed_ms SHALL hold its value in RELEASE, IDLE and ERROR.
REQ-028 mode_done high in IDLE/RELEASE/ERROR SHALL have no effect.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, state_code 0, mode_active 0, mode_start 0, elapsed_ms 0, error_flag 0.
REQ-030 Reset during any state, including mid-ACTIVE, SHALL abandon the mode without mode_start or RELEASE.
REQ-031 After reset release, first transition SHALL occur no earlier than the first rising edge with reset_n high.

Verification
REQ-032 request_n=4'b1101 one cycle in IDLE -> next cycle state_code 2, mode_active 4'b0010, mode_start single pulse.
REQ-033 request_n=4'b0110 simultaneous -> mode 0 wins, state_code 1; mode_done[1]=1 ignored; mode_done[0]=1 -> RELEASE, state_code 0.
REQ-034 Hold request_n[2] low through mode_done[2] -> stays RELEASE, no second mode_start until released, then IDLE.
REQ-035 TIMEOUT_MS=5, mode 3 active, no done, 5 ticks -> state_code 8, error_flag 1, elapsed_ms 5; error_clear -> IDLE.
REQ-036 Same cycle as timeout tick assert mode_done[k] -> RELEASE, not ERROR; abort_n low in ACTIVE -> RELEASE.
REQ-037 reset_n low mid-ACTIVE with elapsed_ms 3 -> immediately all outputs 0, IDLE.
